clarvi_soc_key_input_pio: RTL and testbench



---
 rtl/clarvi_pio_pkg.sv | 14 +
 rtl/clarvi_pio_debounce_bit.sv | 66 ++++++
 rtl/clarvi_soc_key_input_pio.sv | 90 +++++++++
 tb/tb_clarvi_soc_key_input_pio.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clarvi_pio_pkg.sv
// rtl/clarvi_pio_pkg.sv - register map and edge-rule encodings for the key input PIO
package clarvi_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd1;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    typedef enum logic [1:0] {
        EDGE_RISING  = 2'd0,
        EDGE_FALLING = 2'd1,
        EDGE_ANY     = 2'd2
    } edge_type_e;

endpackage

// File: rtl/clarvi_pio_debounce_bit.sv
// rtl/clarvi_pio_debounce_bit.sv - synchroniser plus optional debounce filter for one input bit
module clarvi_pio_debounce_bit #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_i,
    output logic filt_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign filt_o = synced;
        end else begin : g_filter
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0] cnt_q, cnt_d;
            logic          filt_q, filt_d;
            logic          next_synced;

            // The stage feeding the last flop tells us the synced bit flips on this edge.
            assign next_synced = sync_q[SYNC_STAGES-2];

            always_comb begin
                cnt_d  = cnt_q;
                filt_d = filt_q;
                if (synced == filt_q || synced != next_synced) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    filt_d = synced;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_q  <= '0;
                    filt_q <= 1'b0;
                end else begin
                    cnt_q  <= cnt_d;
                    filt_q <= filt_d;
                end
            end

            assign filt_o = filt_q;
        end
    endgenerate

endmodule

// File: rtl/clarvi_soc_key_input_pio.sv
// rtl/clarvi_soc_key_input_pio.sv - Avalon-MM input PIO with edge capture and maskable irq
module clarvi_soc_key_input_pio
    import clarvi_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int PW = $clog2(SYNC_STAGES + 2);
    localparam logic [PW-1:0] PRIME_DONE = PW'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] filt, prev_q, det, w1c;
    logic [WIDTH-1:0] edgecap_q, edgecap_d, irqmask_q, irqmask_d;
    logic [PW-1:0]    prime_q, prime_d;
    logic             primed, wr_en, irq_q, irq_d;
    logic             unused_wdata;

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        clarvi_pio_debounce_bit #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk    (clk),
            .reset_n(reset_n),
            .in_i   (in_port[b]),
            .filt_o (filt[b])
        );
    end

    assign unused_wdata = ^writedata;
    assign wr_en        = chipselect && !write_n;
    // Inputs already high at reset release reach prev only after the chain fills; ignore that edge.
    assign primed       = (prime_q == PRIME_DONE);

    always_comb begin
        prime_d = primed ? prime_q : prime_q + 1'b1;
        if (EDGE_TYPE == int'(EDGE_FALLING)) begin
            det = ~filt & prev_q;
        end else if (EDGE_TYPE == int'(EDGE_ANY)) begin
            det = filt ^ prev_q;
        end else begin
            det = filt & ~prev_q;
        end
        w1c       = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
        edgecap_d = (edgecap_q & ~w1c) | (primed ? det : '0);
        irqmask_d = (wr_en && address == ADDR_IRQMASK) ? writedata[WIDTH-1:0] : irqmask_q;
        irq_d     = |(edgecap_q & irqmask_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q    <= '0;
            edgecap_q <= '0;
            irqmask_q <= '0;
            irq_q     <= 1'b0;
            prime_q   <= '0;
        end else begin
            prev_q    <= filt;
            edgecap_q <= edgecap_d;
            irqmask_q <= irqmask_d;
            irq_q     <= irq_d;
            prime_q   <= prime_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata[WIDTH-1:0] = filt;
            ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask_q;
            ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap_q;
            default:      readdata = '0;
        endcase
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_clarvi_soc_key_input_pio.sv
// tb/tb_clarvi_soc_key_input_pio.sv - bench for the key input PIO (plain and debounced instances)
module tb_clarvi_soc_key_input_pio;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'h0;
    logic [3:0]  in_port = 4'hF;
    logic [31:0] rd_a, rd_b;
    logic        irq_a, irq_b;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    clarvi_soc_key_input_pio #(.WIDTH(4), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_a), .in_port(in_port), .irq(irq_a)
    );

    clarvi_soc_key_input_pio #(.WIDTH(4), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(8), .EDGE_TYPE(2)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_b), .in_port(in_port), .irq(irq_b)
    );

    // Reference model: filtered value judged from a window of past input samples.
    logic [3:0] m_filt[2], m_prev[2], m_cap[2], m_mask[2];
    logic       m_irq[2];
    int         m_edges;
    logic [3:0] in_hist[$];

    function automatic int dcyc(int i);
        return (i == 0) ? 0 : 8;
    endfunction

    function automatic int etype(int i);
        return (i == 0) ? 0 : 2;
    endfunction

    function automatic logic [3:0] hist_at(int k);
        if (k < in_hist.size()) return in_hist[k];
        return 4'h0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_filt[i] = 4'h0; m_prev[i] = 4'h0; m_cap[i] = 4'h0; m_mask[i] = 4'h0; m_irq[i] = 1'b0;
        end
        m_edges = 0;
        in_hist.delete();
    endtask

    task automatic model_step();
        logic       wr;
        logic [3:0] w1c, det, nf, h;
        bit         stable;
        wr = chipselect && !write_n;
        in_hist.push_front(in_port);
        if (in_hist.size() > 32) void'(in_hist.pop_back());
        m_edges++;
        for (int i = 0; i < 2; i++) begin
            for (int b = 0; b < 4; b++) begin
                if (dcyc(i) == 0) begin
                    h = hist_at(S - 1);
                    nf[b] = h[b];
                end else begin
                    stable = 1'b1;
                    for (int k = 0; k <= dcyc(i); k++) begin
                        h = hist_at(S - 1 + k);
                        if (h[b] == m_filt[i][b]) stable = 1'b0;
                    end
                    nf[b] = stable ? ~m_filt[i][b] : m_filt[i][b];
                end
            end
            case (etype(i))
                0:       det = m_filt[i] & ~m_prev[i];
                1:       det = ~m_filt[i] & m_prev[i];
                default: det = m_filt[i] ^ m_prev[i];
            endcase
            if (m_edges < S + 2) det = 4'h0;
            w1c = (wr && address == 2'd3) ? writedata[3:0] : 4'h0;
            m_irq[i] = |(m_cap[i] & m_mask[i]);
            m_cap[i] = (m_cap[i] & ~w1c) | det;
            if (wr && address == 2'd1) m_mask[i] = writedata[3:0];
            m_prev[i] = m_filt[i];
            m_filt[i] = nf;
        end
    endtask

    function automatic logic [31:0] model_rd(int i, logic [1:0] a);
        case (a)
            2'd0:    return {28'h0, m_filt[i]};
            2'd1:    return {28'h0, m_mask[i]};
            2'd3:    return {28'h0, m_cap[i]};
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_clear();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("model_rd_a", rd_a, model_rd(0, address));
            chk("model_rd_b", rd_b, model_rd(1, address));
            chk("model_irq_a", 32'(irq_a), 32'(m_irq[0]));
            chk("model_irq_b", 32'(irq_b), 32'(m_irq[1]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a);
        address = a;
        #1;
    endtask

    typedef struct {
        bit          wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{1'b1, 2'd1, 32'hFFFF_FFF5, 32'h5};
        tbl[1] = '{1'b0, 2'd1, 32'h0,         32'h5};
        tbl[2] = '{1'b1, 2'd0, 32'hFFFF_FFFF, 32'hF};
        tbl[3] = '{1'b1, 2'd2, 32'hFFFF_FFFF, 32'h0};
        tbl[4] = '{1'b0, 2'd3, 32'h0,         32'h0};
        tbl[5] = '{1'b1, 2'd1, 32'h0,         32'h0};
        tbl[6] = '{1'b0, 2'd1, 32'h0,         32'h0};

        // Reset held with inputs high, then release.
        repeat (3) tick();
        rd(2'd0); chk("rst_data", rd_a, 32'h0);
        rd(2'd3); chk("rst_cap", rd_a, 32'h0);
        chk("rst_irq", 32'(irq_a), 32'h0);
        reset_n = 1'b1;
        repeat (10) tick();
        rd(2'd0); chk("prime_data", rd_a, 32'hF);
        rd(2'd3); chk("prime_cap", rd_a, 32'h0);
        chk("prime_irq", 32'(irq_a), 32'h0);

        for (int i = 0; i < 7; i++) begin
            if (tbl[i].wr) wr(tbl[i].addr, tbl[i].wdata);
            else tick();
            rd(tbl[i].addr);
            chk($sformatf("tbl%0d", i), rd_a, tbl[i].exp);
        end

        // Rising-edge latency on bit 0.
        wr(2'd1, 32'h1);
        in_port = 4'h0;
        repeat (20) tick();
        wr(2'd3, 32'hF);
        address = 2'd0;
        in_port = 4'h1;
        tick(); chk("lat_data_n1", rd_a, 32'h0);
        tick(); chk("lat_data_n2", rd_a, 32'h1);
        address = 2'd3;
        tick(); chk("lat_cap_n3", rd_a, 32'h1); chk("lat_irq_n3", 32'(irq_a), 32'h0);
        tick(); chk("lat_irq_n4", 32'(irq_a), 32'h1);
        wr(2'd3, 32'h1);
        chk("w1c_cap", rd_a, 32'h0); chk("w1c_irq_hold", 32'(irq_a), 32'h1);
        tick(); chk("w1c_irq_drop", 32'(irq_a), 32'h0);

        // W1C coinciding with a fresh capture: set wins.
        in_port = 4'h0; repeat (5) tick();
        in_port = 4'h1; repeat (4) tick();
        chk("pre_cap", rd_a, 32'h1); chk("pre_irq", 32'(irq_a), 32'h1);
        in_port = 4'h0; repeat (5) tick();
        in_port = 4'h1; tick(); tick();
        wr(2'd3, 32'h1);
        chk("race_cap", rd_a, 32'h1); chk("race_irq", 32'(irq_a), 32'h1);
        tick();
        chk("race_cap2", rd_a, 32'h1); chk("race_irq2", 32'(irq_a), 32'h1);

        // Debounce: short pulse rejected, long level accepted after 8 stable cycles.
        in_port = 4'h1; repeat (20) tick();
        wr(2'd3, 32'hF);
        rd(2'd0); chk("db_base", rd_b, 32'h1);
        in_port = 4'h3; repeat (5) tick();
        in_port = 4'h1; repeat (15) tick();
        rd(2'd0); chk("db_pulse_data", rd_b, 32'h1);
        rd(2'd3); chk("db_pulse_cap", rd_b, 32'h0);
        address = 2'd0;
        in_port = 4'h3;
        repeat (9) tick(); chk("db_hold_early", rd_b, 32'h1);
        tick(); chk("db_hold_exact", rd_b, 32'h3);
        repeat (3) tick();

        // Any-edge capture under a zero mask, then unmask.
        wr(2'd1, 32'h0);
        wr(2'd3, 32'hF);
        in_port = 4'h7; repeat (14) tick();
        rd(2'd3); chk("any_cap_b", rd_b, 32'h4); chk("any_irq_b", 32'(irq_b), 32'h0);
        chk("rise_cap_a", rd_a, 32'h4);
        wr(2'd1, 32'h4);
        chk("mask_irq_b0", 32'(irq_b), 32'h0);
        tick(); chk("mask_irq_b1", 32'(irq_b), 32'h1);
        wr(2'd0, 32'hFFFF_FFFF);
        rd(2'd0); chk("ro_data_a", rd_a, 32'h7); chk("ro_data_b", rd_b, 32'h7);
        rd(2'd1); chk("mask_rb", rd_b, 32'h4);

        // Asynchronous reset while captures are pending.
        wr(2'd1, 32'h3);
        in_port = 4'h0; repeat (14) tick();
        wr(2'd3, 32'hF);
        in_port = 4'h3; repeat (14) tick();
        rd(2'd3); chk("pre_rst_cap_a", rd_a, 32'h3); chk("pre_rst_cap_b", rd_b, 32'h3);
        chk("pre_rst_irq_a", 32'(irq_a), 32'h1);
        tick();
        #2 reset_n = 1'b0;
        #1;
        chk("arst_cap_a", rd_a, 32'h0); chk("arst_cap_b", rd_b, 32'h0);
        chk("arst_irq_a", 32'(irq_a), 32'h0); chk("arst_irq_b", 32'(irq_b), 32'h0);
        tick();
        reset_n = 1'b1;

        // Randomised traffic checked against the model every cycle.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(15) == 0) in_port = 4'($urandom_range(15));
            address = 2'($urandom_range(3));
            if ($urandom_range(3) == 0) begin
                chipselect = 1'b1; write_n = 1'b0; writedata = $urandom;
            end else begin
                chipselect = 1'($urandom_range(1)); write_n = 1'b1; writedata = $urandom;
            end
            if (n == 700) begin
                reset_n = 1'b0;
                tick(); tick();
                reset_n = 1'b1;
            end
            tick();
        end
        chipselect = 1'b0; write_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
